score_pulse_gen: RTL
====================

// Module: score_pulse_gen
//
// PURPOSE
//   Converts hit events (each worth N points) into a train of single-cycle
//   enable pulses, one pulse per point, that drives the enable input of the
//   least-significant BCD digit in the score counter chain.
//   Sits between the collision/hit logic (upstream) and the score digit chain
//   (downstream). Buffers pending points, so bursts of hits are never lost.
//   Pulses are spaced so the digit chain sees at most one increment per pulse slot.
//
// PARAMETERS
//   PTS_W   4   width of hit_points (max points per event = 2^PTS_W-1)
//   PEND_W  8   width of pending-points accumulator
//   GAP     0   idle cycles forced between consecutive score_enable pulses
//
// PORTS
//   clock         in   1       system clock, all logic on posedge
//   reset         in   1       synchronous, active-high
//   hit_valid     in   1       one hit event this cycle
//   hit_points    in   PTS_W   points for the hit, sampled when hit_valid=1
//   freeze        in   1       game-over hold: no pulses issued, hits still accepted
//   clear         in   1       drop all pending points, clear overflow
//   score_enable  out  1       registered 1-cycle pulse = +1 point to digit chain
//   pending       out  PEND_W  points accepted but not yet pulsed
//   busy          out  1       pending != 0 or state != IDLE
//   overflow      out  1       sticky: accumulator saturated, points were lost
//
// BEHAVIOUR
//   - Reset: score_enable=0, pending=0, overflow=0, busy=0, state=IDLE.
//   - States: IDLE (may pulse), WAIT (GAP countdown). With GAP=0, WAIT is never entered.
//   - Pulse rule, evaluated at each edge:
//     in IDLE with pending>0 and !freeze and !clear, drive score_enable<=1 next cycle
//     and decrement pending by 1 at that edge; otherwise score_enable<=0.
//   - After a pulse with GAP>0: go to WAIT, load gap count = GAP.
//     Leave WAIT to IDLE after GAP cycles with score_enable=0.
//     Result: pulse period = GAP+1 cycles.
//   - Accumulate: pending_next = pending + (hit_valid ? hit_points : 0) - pulse_taken.
//     Compute in PEND_W+1 bits. If the result exceeds 2^PEND_W-1, saturate to
//     2^PEND_W-1 and set overflow. Never wrap.
//   - A hit and a pulse on the same edge: both are applied. Example: pending=3,
//     hit of 2 gives pending=4.
//   - hit_points=0 with hit_valid=1 is a no-op.
//   - Latency: hit accepted at edge k (pending was 0, IDLE, !freeze) gives
//     score_enable=1 during cycle k+1.
//   - freeze: pulses stop immediately, pending holds plus accepts, WAIT countdown continues.
//     Deasserting freeze resumes pulsing on the next edge.
//   - clear: highest priority after reset. pending<=0, overflow<=0, state<=IDLE,
//     score_enable<=0. A hit in the same cycle is dropped.
//   - Reset mid-burst: all outputs return to reset values at that edge.
//     Outstanding points are discarded.
//   - Invariant: total pulses issued = total points accepted - points cleared - points lost.
//
// STRUCTURE
//   - score_pkg: localparams for state encoding (ST_IDLE, ST_WAIT), plus the
//     PEND_MAX = {PEND_W{1'b1}} helper.
//   - One sub-module: gap_timer (loadable down-counter, done flag), instantiated
//     only when GAP>0 (generate).
//   - The accumulator/saturation datapath and the FSM live in this module.
//
// TESTING
//   1. Reset then idle 20 cycles -> score_enable never 1, pending=0, busy=0.
//   2. GAP=0, one hit of 5 -> exactly 5 consecutive pulses starting 1 cycle after
//      accept. pending steps 4,3,2,1,0; busy falls after the last pulse.
//   3. GAP=2, hit of 3 -> pulses at cycles k+1, k+4, k+7; no other pulses.
//   4. pending=3 mid-burst, hit of 2 on a pulse edge -> pending=4; total pulses = 5 from that point.
//   5. PEND_W=4: 16 hits of 15 back-to-back -> pending=15, overflow=1.
//      clear -> pending=0, overflow=0, pulses stop the next cycle.
//   6. freeze asserted with pending=4 -> no pulses and pending holds; hit of 1
//      gives pending=5. Release freeze -> exactly 5 pulses.
//      Reset asserted during those pulses -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/score_pulse_gen_pkg.sv
// Shared types and helpers for the score pulse generator slice.
package score_pulse_gen_pkg;

  // Pulse scheduler states: IDLE may issue a pulse, WAIT burns the gap.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam int PTS_W_DEF  = 4;
  localparam int PEND_W_DEF = 8;
  localparam int GAP_DEF    = 0;

  // Largest value a w-bit accumulator can hold (all ones).
  function automatic int unsigned pend_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/score_pulse_gen_if.sv
// Bus between the hit logic / game control and the score pulse generator.
//
// Handshake: hit_valid is a one-cycle event with no ready. Every hit whose
// hit_valid is high at a clock edge is accepted at that edge (unless clear or
// reset is high); back-pressure is absorbed by the pending accumulator, which
// saturates and flags overflow rather than stalling the producer.
interface score_pulse_gen_if #(
  parameter int PTS_W  = 4,
  parameter int PEND_W = 8
);
  import score_pulse_gen_pkg::*;

  logic              hit_valid;
  logic [PTS_W-1:0]  hit_points;
  logic              freeze;
  logic              clear;
  logic              score_enable;
  logic [PEND_W-1:0] pending;
  logic              busy;
  logic              overflow;
  state_e            dbg_state;

  modport master (
    output hit_valid, hit_points, freeze, clear,
    input  score_enable, pending, busy, overflow, dbg_state
  );

  modport slave (
    input  hit_valid, hit_points, freeze, clear,
    output score_enable, pending, busy, overflow, dbg_state
  );

endinterface

// File: rtl/score_pulse_gen_gap_timer.sv
// Loadable down-counter that times the idle gap between score pulses.
// done_o is high during the last counted cycle so the FSM leaves WAIT on time.
module gap_timer #(
  parameter int GAP = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic load_i,
  input  logic tick_i,
  output logic done_o
);

  localparam int W = $clog2(GAP + 1);

  logic [W-1:0] cnt_q;

  // Counter: load GAP on a pulse, count down once per WAIT cycle.
  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= W'(GAP);
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/score_pulse_gen.sv
// Turns hit events worth N points into N single-cycle score_enable pulses,
// spaced GAP idle cycles apart, buffering points in a saturating accumulator.
module score_pulse_gen
  import score_pulse_gen_pkg::*;
#(
  parameter int PTS_W  = PTS_W_DEF,
  parameter int PEND_W = PEND_W_DEF,
  parameter int GAP    = GAP_DEF
) (
  input  logic             clock,
  input  logic             reset,
  score_pulse_gen_if.slave bus
);

  localparam logic [PEND_W:0] PEND_MAX = (PEND_W + 1)'(pend_max(PEND_W));

  state_e            state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              en_q;
  logic              pulse;
  logic              in_wait;
  logic              timer_done;
  logic [PEND_W:0]   hit_ext;
  logic [PEND_W:0]   sum;

  assign in_wait = (state_q == ST_WAIT);

  // Accumulator: add the accepted hit, subtract the pulse taken, saturate.
  always_comb begin
    hit_ext = '0;
    pulse   = 1'b0;
    sum     = '0;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    if (bus.hit_valid) begin
      hit_ext = (PEND_W + 1)'(bus.hit_points);
    end
    pulse = (state_q == ST_IDLE) && (pend_q != '0) && !bus.freeze && !bus.clear;
    // One spare bit so the sum can exceed PEND_MAX without wrapping.
    sum = {1'b0, pend_q} + hit_ext - (PEND_W + 1)'(pulse);
    if (bus.clear) begin
      pend_d = '0;
      ovf_d  = 1'b0;
    end else if (sum > PEND_MAX) begin
      pend_d = PEND_MAX[PEND_W-1:0];
      ovf_d  = 1'b1;
    end else begin
      pend_d = sum[PEND_W-1:0];
    end
  end

  // Next state: after a pulse sit in WAIT until the gap timer expires.
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (pulse && (GAP > 0)) state_d = ST_WAIT;
        ST_WAIT: if (timer_done)         state_d = ST_IDLE;
        default:                         state_d = ST_IDLE;
      endcase
    end
  end

  // State, accumulator and registered pulse output.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      en_q    <= pulse;
    end
  end

  generate
    if (GAP > 0) begin : g_timer
      gap_timer #(.GAP(GAP)) u_gap_timer (
        .clock   (clock),
        .reset   (reset),
        .clear_i (bus.clear),
        .load_i  (pulse),
        .tick_i  (in_wait),
        .done_o  (timer_done)
      );
    end else begin : g_no_timer
      // No gap: WAIT is never entered, so the timer is always "done".
      assign timer_done = 1'b1;
    end
  endgenerate

  assign bus.score_enable = en_q;
  assign bus.pending      = pend_q;
  assign bus.busy         = (pend_q != '0) || (state_q != ST_IDLE);
  assign bus.overflow     = ovf_q;
  assign bus.dbg_state    = state_q;

endmodule
